// File: rtl/timer_bank_if.sv
// timer_bank_if: peripheral bus bundle for timer_bank.
//   rd/wr      read and write strobes (wr sampled on rising clk)
//   addr       byte address
//   wdata      write data
//   rdata      combinational read data (0 when rd low or unmapped)
//   irq_vec    per-channel interrupt request, pending & enable
//   irqout     OR of irq_vec
// Modports: master drives the strobes, slave is the timer bank.
interface timer_bank_if #(
   parameter int NUM_CH = 4
);
   logic              rd;
   logic              wr;
   logic [31:0]       addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic [NUM_CH-1:0] irq_vec;
   logic              irqout;

   modport master (output rd, wr, addr, wdata, input rdata, irq_vec, irqout);
   modport slave  (input rd, wr, addr, wdata, output rdata, irq_vec, irqout);
endinterface

// File: rtl/timer_bank.sv
// timer_bank: memory-mapped bank of NUM_CH up-counting timers with reload,
// one-shot mode, W1C pending flags and per-channel interrupt enable.
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    timer_bank_if.slave (rd, wr, addr, wdata, rdata, irq_vec, irqout)
// Channel n lives at BASE_ADDR + 16*n: +0 RELOAD, +4 COUNT, +8 CTRL
// (EN/IE/ONESHOT), +C STATUS (PEND, write 1 clears). IRQSUM follows the last
// channel. Build macro TIMER_BANK_PRESCALE_EN adds a shared 16-bit tick
// prescaler (PRESC at IRQSUM+4); without it every clk cycle is a tick.

// Per-channel counter, reload, control and pending state.
module timer_bank_ch #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick_i,
   input  logic             wr_reload_i,
   input  logic             wr_count_i,
   input  logic             wr_ctrl_i,
   input  logic             wr_status_i,
   input  logic [CNT_W-1:0] wdata_i,
   output logic [CNT_W-1:0] reload_o,
   output logic [CNT_W-1:0] count_o,
   output logic [2:0]       ctrl_o,
   output logic             pend_o
);
   logic [CNT_W-1:0] reload_q, reload_d, count_q, count_d;
   logic [2:0]       ctrl_q, ctrl_d;
   logic             pend_q, pend_d;
   logic             ovf;

   assign ovf = ctrl_q[0] && tick_i && (count_q == {CNT_W{1'b1}});

   always_comb begin
      reload_d = reload_q;
      count_d  = count_q;
      ctrl_d   = ctrl_q;
      pend_d   = pend_q;
      if (ctrl_q[0] && tick_i)
         // reload uses reload_q, so a RELOAD write in this cycle takes
         // effect only from the next overflow
         count_d = ovf ? reload_q : count_q + 1'b1;
      if (ovf && ctrl_q[2])
         ctrl_d[0] = 1'b0;
      if (wr_status_i && wdata_i[0])
         pend_d = 1'b0;
      // set beats clear; software writes beat counter activity
      if (ovf)          pend_d   = 1'b1;
      if (wr_reload_i)  reload_d = wdata_i;
      if (wr_count_i)   count_d  = wdata_i;
      if (wr_ctrl_i)    ctrl_d   = wdata_i[2:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reload_q <= '0;
         count_q  <= '0;
         ctrl_q   <= '0;
         pend_q   <= 1'b0;
      end else begin
         reload_q <= reload_d;
         count_q  <= count_d;
         ctrl_q   <= ctrl_d;
         pend_q   <= pend_d;
      end
   end

   assign reload_o = reload_q;
   assign count_o  = count_q;
   assign ctrl_o   = ctrl_q;
   assign pend_o   = pend_q;
endmodule

module timer_bank #(
   parameter int          NUM_CH    = 4,
   parameter int          CNT_W     = 32,
   parameter logic [31:0] BASE_ADDR = 32'h40000100
) (
   input  logic        clk,
   input  logic        reset,
   timer_bank_if.slave bus
);
   localparam logic [31:0] GLB_OFF = 32'(16 * NUM_CH);

   logic [NUM_CH-1:0][CNT_W-1:0] reload, count;
   logic [NUM_CH-1:0][2:0]       ctrl;
   logic [NUM_CH-1:0]            pend, irq;
   logic [31:0]                  off;
   logic [31:0]                  rdata_c;
   logic                         tick;

   // Addresses below BASE_ADDR wrap to a huge offset and decode as unmapped.
   assign off = bus.addr - BASE_ADDR;

`ifdef TIMER_BANK_PRESCALE_EN
   logic [15:0] presc_q, presc_d, div_q, div_d;
   logic        wr_presc;

   assign wr_presc = bus.wr && (off == GLB_OFF + 32'd4);
   assign tick     = (div_q == presc_q);

   always_comb begin
      presc_d = presc_q;
      div_d   = tick ? 16'd0 : div_q + 16'd1;
      if (wr_presc) begin
         presc_d = bus.wdata[15:0];
         div_d   = 16'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
         div_q   <= '0;
      end else begin
         presc_q <= presc_d;
         div_q   <= div_d;
      end
   end
`else
   assign tick = 1'b1;
`endif

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      logic hit;
      assign hit = (off[31:4] == 28'(n)) && (off[1:0] == 2'b00);

      timer_bank_ch #(.CNT_W(CNT_W)) u_ch (
         .clk        (clk),
         .reset      (reset),
         .tick_i     (tick),
         .wr_reload_i(bus.wr && hit && (off[3:2] == 2'd0)),
         .wr_count_i (bus.wr && hit && (off[3:2] == 2'd1)),
         .wr_ctrl_i  (bus.wr && hit && (off[3:2] == 2'd2)),
         .wr_status_i(bus.wr && hit && (off[3:2] == 2'd3)),
         .wdata_i    (bus.wdata[CNT_W-1:0]),
         .reload_o   (reload[n]),
         .count_o    (count[n]),
         .ctrl_o     (ctrl[n]),
         .pend_o     (pend[n])
      );

      assign irq[n] = pend[n] & ctrl[n][1];
   end

   always_comb begin
      rdata_c = '0;
      if (bus.rd) begin
         for (int n = 0; n < NUM_CH; n++) begin
            if ((off[31:4] == 28'(n)) && (off[1:0] == 2'b00)) begin
               case (off[3:2])
                  2'd0:    rdata_c = 32'(reload[n]);
                  2'd1:    rdata_c = 32'(count[n]);
                  2'd2:    rdata_c = 32'(ctrl[n]);
                  default: rdata_c = 32'(pend[n]);
               endcase
            end
         end
         if (off == GLB_OFF) rdata_c = 32'(irq);
`ifdef TIMER_BANK_PRESCALE_EN
         if (off == GLB_OFF + 32'd4) rdata_c = 32'(presc_q);
`endif
      end
   end

   assign bus.rdata   = rdata_c;
   assign bus.irq_vec = irq;
   assign bus.irqout  = |irq;
endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Memory-mapped bank of NUM_CH independent up-counting timers with reload; parametrised successor of the single TH/TL/TCON timer.
- Sits on the same peripheral bus as the LED/switch/UART registers: rd/wr strobes, 32-bit addr/wdata/rdata.
- Adds one-shot mode, write-1-to-clear pending flags, per-channel interrupt enable and an aggregated interrupt.
- Reads have no side effects.

Parameters:
- NUM_CH, 4: number of timer channels (1..8).
- CNT_W, 32: counter/reload width in bits (8..32).
- BASE_ADDR, 32'h40000100: byte address of channel 0; channel n occupies BASE_ADDR + 16*n.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- rd  input  1  read strobe
- wr  input  1  write strobe, sampled on rising clk
- addr  input  32  byte address
- wdata  input  32  write data
- rdata  output  32  read data, combinational
- irq_vec  output  NUM_CH  per-channel request: pending[n] & IE[n]
- irqout  output  1  OR of irq_vec

Behaviour:
- Register map per channel n (offset from BASE_ADDR+16n):
  - +0 RELOAD (CNT_W, R/W)
  - +4 COUNT (CNT_W, R/W)
  - +8 CTRL: bit0 EN, bit1 IE, bit2 ONESHOT (R/W)
  - +C STATUS: bit0 PEND; reads current value, write 1 clears, write 0 no effect
- Global register at BASE_ADDR+16*NUM_CH: IRQSUM, read-only, {zero-extended irq_vec}.
- Registers are zero-extended to 32 bits on read; writes use wdata[CNT_W-1:0] or the listed bits; undefined bits read 0.
- rdata = 0 when rd=0 or addr unmapped; unmapped writes are ignored.
- Reset: all RELOAD, COUNT, CTRL, PEND = 0; rdata = 0 (rd low); irq_vec = 0; irqout = 0.
- Counting, per tick while EN=1:
  - If COUNT != all-ones: COUNT <= COUNT+1.
  - If COUNT == all-ones (overflow): COUNT <= RELOAD and PEND <= 1; if ONESHOT=1, also EN <= 0.
  - Tick = every clk cycle; see optional feature.
- Overflow period = 2^CNT_W - RELOAD ticks.
- irq_vec/irqout are combinational from registered PEND/IE, so they assert in the cycle after the overflow edge.
- Simultaneous events, same cycle:
  - Software write to COUNT beats both increment and reload; PEND is still set if an overflow occurred that cycle.
  - W1C to STATUS coincident with a new overflow leaves PEND=1 (set wins).
  - Write to CTRL beats the one-shot EN clear.
  - Writing RELOAD during the overflow cycle: the old RELOAD value is loaded; the new value is used from the next reload.
- Clearing EN freezes COUNT; PEND is unaffected. IE=0 masks irq_vec only; PEND still sets.
- Reset asserted mid-count clears everything asynchronously; counting resumes only after software sets EN.

Optional Feature:
- Macro TIMER_BANK_PRESCALE_EN.
- Defined:
  - Adds PRESC register (16-bit R/W, reset 0) at BASE_ADDR+16*NUM_CH+4.
  - A shared 16-bit divider produces one tick every PRESC+1 clk cycles; PRESC=0 gives a tick every cycle.
  - Writing PRESC restarts the divider at 0.
- Not defined: a tick every cycle; that address is unmapped (reads 0, writes ignored).

Test Plan:
- Reset held high with wr pulses applied -> all registers read 0, irqout=0; deassert reset -> COUNT still 0.
- CNT_W=8, ch0 RELOAD=8'hF0, COUNT=8'hFE, CTRL=3 -> after 2 cycles COUNT=8'hF0 and PEND=1; irqout=1 the next cycle; period then 16 cycles.
- ch1 CTRL=5 (EN+ONESHOT, IE=0), COUNT=max -> one cycle later EN reads 0, PEND=1, irq_vec[1]=0, COUNT=RELOAD and frozen.
- Write STATUS=1 in the same cycle as a ch0 overflow -> PEND stays 1; a later write of 1 clears it, irqout drops in the same cycle as the clearing edge.
- Write COUNT=5 coincident with overflow -> COUNT=5, PEND=1; IRQSUM reads match irq_vec for all channels; unmapped address read -> 0.
- With TIMER_BANK_PRESCALE_EN, PRESC=3, COUNT=0, EN=1 -> COUNT=1 after 4 cycles, 2 after 8; without the macro, a PRESC read returns 0.
